// File: rtl/fifo_tg_pkg.sv
// Shared types and constants for the FIFO traffic generator.
package fifo_tg_pkg;

  typedef enum logic [1:0] {
    FILL_DRAIN = 2'd0,
    STREAM     = 2'd1,
    RANDOM     = 2'd2,
    OVERRUN    = 2'd3
  } tg_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } tg_state_e;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } tg_sub_e;

  // x^8 + x^6 + x^5 + x^4 + 1 as a Fibonacci tap mask over bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
  localparam int unsigned HOLD_CYCLES = 3;

endpackage

// File: rtl/fifo_traffic_gen_if.sv
// FIFO-side handshake between the traffic generator (master) and the FIFO (slave).
interface fifo_traffic_gen_if #(
  parameter int unsigned DATA_W = 4
);
  logic              write_en;
  logic [DATA_W-1:0] write_data;
  logic              read_en;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] read_data;

  modport master (
    output write_en, write_data, read_en,
    input  full, empty, read_data
  );

  modport slave (
    input  write_en, write_data, read_en,
    output full, empty, read_data
  );
endinterface

// File: rtl/tg_lfsr8.sv
// 8-bit Fibonacci LFSR; loads SEED on reset and shifts once per enabled cycle.
module tg_lfsr8
  import fifo_tg_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);
  logic [7:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;
endmodule

// File: rtl/fifo_traffic_gen.sv
// Deterministic writer/reader for a small FIFO: writes a wrapping sequence and checks reads in order.
module fifo_traffic_gen
  import fifo_tg_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   num_txn,
  fifo_traffic_gen_if.master fifo,
  output logic               busy,
  output logic               done,
  output logic               mismatch,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   rd_cnt
);
  tg_state_e         state_q, state_d;
  tg_sub_e           sub_q, sub_d;
  tg_mode_e          mode_q, mode_d;
  logic [CNT_W-1:0]  num_q, num_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] wr_seq_q, wr_seq_d, rd_seq_q, rd_seq_d, exp_q, exp_d;
  logic              chk_q, chk_d, mismatch_q, mismatch_d;
  logic [1:0]        hold_q, hold_d;
  logic [7:0]        lfsr;
  logic              unused_lfsr;
  logic              we, re, wa, ra, wr_room, rd_room, start_run;

  tg_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == RUN),
    .state (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sub_q      <= FILL;
      mode_q     <= FILL_DRAIN;
      num_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_seq_q   <= '0;
      rd_seq_q   <= '0;
      exp_q      <= '0;
      chk_q      <= 1'b0;
      mismatch_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_seq_q   <= wr_seq_d;
      rd_seq_q   <= rd_seq_d;
      exp_q      <= exp_d;
      chk_q      <= chk_d;
      mismatch_q <= mismatch_d;
      hold_q     <= hold_d;
    end
  end

  // Run-level FSM plus the FILL/DRAIN/HOLD substate used by modes 0 and 3
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_txn == '0) ? DONE : RUN;
      RUN:     if (wr_cnt_d == num_q && rd_cnt_d == num_q) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_run) begin
      sub_d  = FILL;
      hold_d = '0;
    end else if (state_q == RUN) begin
      case (sub_q)
        FILL: if (fifo.full || !wr_room) sub_d = (mode_q == OVERRUN && fifo.full) ? HOLD : DRAIN;
        HOLD: begin
          if (hold_q == 2'(HOLD_CYCLES - 1)) begin
            sub_d  = DRAIN;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 2'd1;
          end
        end
        DRAIN:   if (fifo.empty) sub_d = FILL;
        default: sub_d = FILL;
      endcase
    end
  end

  // Pass-through reads key off a write that will be taken without needing the read itself
  always_comb begin
    start_run = (state_q == IDLE) && start;
    wr_room   = wr_cnt_q < num_q;
    rd_room   = rd_cnt_q < num_q;
    we        = 1'b0;
    re        = 1'b0;
    if (state_q == RUN) begin
      case (mode_q)
        FILL_DRAIN, OVERRUN: begin
          we = (sub_q == HOLD) || (sub_q == FILL && !fifo.full && wr_room);
          re = (sub_q == DRAIN) && !fifo.empty && rd_room && (rd_cnt_q < wr_cnt_q);
        end
        STREAM: begin
          we = wr_room;
          re = rd_room && ((rd_cnt_q < wr_cnt_q) || (we && !fifo.full));
        end
        RANDOM: begin
          we = lfsr[0] && wr_room;
          re = lfsr[1] && rd_room && ((rd_cnt_q < wr_cnt_q) || (we && !fifo.full));
        end
        default: ;
      endcase
    end
    wa = we && (!fifo.full || re);
    ra = re && (!fifo.empty || we);
  end

  always_comb begin
    mode_d     = mode_q;
    num_d      = num_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_seq_d   = wr_seq_q;
    rd_seq_d   = rd_seq_q;
    mismatch_d = mismatch_q;
    chk_d      = ra;
    exp_d      = rd_seq_q;
    if (start_run) begin
      mode_d     = tg_mode_e'(mode);
      num_d      = num_txn;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      mismatch_d = 1'b0;
    end else begin
      if (wa) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        wr_seq_d = wr_seq_q + 1'b1;
      end
      if (ra) begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        rd_seq_d = rd_seq_q + 1'b1;
      end
      if (chk_q && fifo.read_data != exp_q) mismatch_d = 1'b1;
    end
  end

  assign fifo.write_en   = we;
  assign fifo.write_data = wr_seq_q;
  assign fifo.read_en    = re;
  assign busy            = (state_q == RUN) || (state_q == FLUSH);
  assign done            = (state_q == DONE);
  assign mismatch        = mismatch_q;
  assign wr_cnt          = wr_cnt_q;
  assign rd_cnt          = rd_cnt_q;
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Bench: 4-deep FIFO responder with optional read corruption, run-level reference model, directed + random runs.
module tb_fifo_traffic_gen;
  localparam int DW = 4;
  localparam int CW = 8;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_FLUSH = 2, ST_DONE = 3;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    mode;
  logic [CW-1:0] num_txn;
  logic          busy, done, mismatch;
  logic [CW-1:0] wr_cnt, rd_cnt;

  fifo_traffic_gen_if #(.DATA_W(DW)) fif ();

  fifo_traffic_gen #(.DATA_W(DW), .CNT_W(CW), .LFSR_SEED(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .num_txn  (num_txn),
    .fifo     (fif),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // 4-deep FIFO with same-cycle pass-through; optionally corrupts the Nth read of a run
  logic [DW-1:0] q[$];
  int unsigned   fcnt = 0;
  int unsigned   f_rd_n = 0;
  int unsigned   corrupt_idx = 0;
  logic          f_wa, f_ra;
  logic [DW-1:0] f_d;

  assign fif.full  = (fcnt == 4);
  assign fif.empty = (fcnt == 0);

  always @(posedge clk) begin
    f_wa = fif.write_en && (!fif.full || fif.read_en);
    f_ra = fif.read_en && (!fif.empty || fif.write_en);
    if (rst) begin
      q.delete();
      fcnt          <= 0;
      f_rd_n        <= 0;
      fif.read_data <= '0;
    end else begin
      if (start && !busy && !done) f_rd_n <= 0;
      if (f_wa) q.push_back(fif.write_data);
      if (f_ra) begin
        f_d = (q.size() != 0) ? q.pop_front() : '0;
        if (f_rd_n + 1 == corrupt_idx) f_d = f_d ^ 4'h1;
        fif.read_data <= f_d;
        f_rd_n        <= f_rd_n + 1;
      end
      fcnt <= q.size();
    end
  end

  // Reference model: run bookkeeping from the behavioural rules, advanced once per cycle
  int            m_stage = ST_IDLE;
  int            m_wr, m_rd, m_num, m_mode, m_hold, m_busy_cycles, m_first_rd;
  int unsigned   m_wtot;
  logic          m_mis, m_pend, m_valid = 1'b0;
  logic [7:0]    m_lfsr;
  logic [DW-1:0] wlog[$];
  logic          o_we, o_re, o_full, o_empty, o_wa, o_ra, e_we, e_re;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always @(negedge clk) begin
    o_we    = fif.write_en;
    o_re    = fif.read_en;
    o_full  = fif.full;
    o_empty = fif.empty;
    if (m_valid) begin
      check("busy", busy, (m_stage == ST_RUN || m_stage == ST_FLUSH));
      check("done", done, (m_stage == ST_DONE));
      check("wr_cnt", wr_cnt, m_wr);
      check("rd_cnt", rd_cnt, m_rd);
      check("mismatch", mismatch, m_mis);
      if (o_we) check("write_data", fif.write_data, m_wtot % 16);
      if (m_stage != ST_RUN) begin
        check("write_en_off", o_we, 1'b0);
        check("read_en_off", o_re, 1'b0);
      end else if (m_mode == 1 || m_mode == 2) begin
        e_we = (m_wr < m_num) && (m_mode == 1 || m_lfsr[0]);
        e_re = (m_rd < m_num) && (m_mode == 1 || m_lfsr[1]) && ((m_rd < m_wr) || (e_we && !o_full));
        check("write_en", o_we, e_we);
        check("read_en", o_re, e_re);
      end else begin
        check("one_enable", o_we && o_re, 1'b0);
        if (o_re) check("read_has_data", !o_empty && (m_rd < m_wr), 1'b1);
        if (o_we && (m_mode == 0 || !o_full)) check("write_room", !o_full && (m_wr < m_num), 1'b1);
      end
    end
    o_wa = o_we && (!o_full || o_re);
    o_ra = o_re && (!o_empty || o_we);
    if (rst) begin
      m_stage = ST_IDLE; m_wr = 0; m_rd = 0; m_wtot = 0; m_mis = 1'b0; m_pend = 1'b0;
      m_lfsr = 8'hA5; m_valid = 1'b1;
    end else begin
      m_mis  = m_mis | m_pend;
      m_pend = 1'b0;
      case (m_stage)
        ST_IDLE: if (start) begin
          m_num = int'(num_txn); m_mode = int'(mode); m_wr = 0; m_rd = 0; m_mis = 1'b0;
          m_hold = 0; m_busy_cycles = 0; m_first_rd = -1; wlog.delete();
          m_stage = (m_num == 0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          m_busy_cycles++;
          m_lfsr = lfsr_step(m_lfsr);
          if (m_mode == 3 && o_we && o_full && !o_re) m_hold++;
          if (o_ra) begin
            if (m_first_rd < 0) m_first_rd = m_wr;
            if (m_rd + 1 == int'(corrupt_idx)) m_pend = 1'b1;
            m_rd++;
          end
          if (o_wa) begin
            wlog.push_back(DW'(m_wtot % 16));
            m_wr++;
            m_wtot++;
          end
          if (m_wr == m_num && m_rd == m_num) m_stage = ST_FLUSH;
        end
        ST_FLUSH: begin m_busy_cycles++; m_stage = ST_DONE; end
        default:  m_stage = ST_IDLE;
      endcase
    end
  end

  task automatic pulse_start(input int md, input int n);
    @(posedge clk); #2;
    mode = 2'(md); num_txn = CW'(n); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check("done_timeout", done, 1'b1);
  endtask

  int cyc, n, md;

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; num_txn = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_write_en", fif.write_en, 1'b0);
    check("rst_write_data", fif.write_data, 0);
    rst = 1'b0;

    pulse_start(0, 8);
    wait_done(500, cyc);
    check("fd_mismatch", mismatch, 1'b0);
    check("fd_wr_cnt", wr_cnt, 8);
    check("fd_rd_cnt", rd_cnt, 8);
    check("fd_cycles", (cyc >= 16), 1'b1);
    check("fd_first_read_after", m_first_rd, 4);
    check("fd_wdata0", wlog[0], 0);
    check("fd_wdata3", wlog[3], 3);

    pulse_start(1, 20);
    wait_done(500, cyc);
    check("st_busy_cycles", cyc, 21);
    check("st_model_busy", m_busy_cycles, 21);
    check("st_wr_cnt", wr_cnt, 20);
    check("st_rd_cnt", rd_cnt, 20);
    check("st_first_wdata", wlog[0], 8);
    check("st_last_wdata", wlog[19], 11);

    pulse_start(3, 4);
    wait_done(500, cyc);
    check("ov_hold", m_hold, 3);
    check("ov_wr_cnt", wr_cnt, 4);
    check("ov_mismatch", mismatch, 1'b0);
    check("ov_wdata0", wlog[0], 12);

    corrupt_idx = 3;
    pulse_start(0, 8);
    wait_done(500, cyc);
    check("cor_mismatch_done", mismatch, 1'b1);
    corrupt_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    check("cor_mismatch_held", mismatch, 1'b1);

    pulse_start(0, 0);
    check("zero_mismatch_cleared", mismatch, 1'b0);
    wait_done(10, cyc);
    check("zero_done_latency", cyc, 0);

    pulse_start(2, 30);
    repeat (5) @(posedge clk);
    #2; mode = 2'd1; num_txn = CW'(3); start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_done(2000, cyc);
    check("busy_start_ignored", wr_cnt, 30);

    for (int r = 0; r < 12; r++) begin
      md = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 40));
      corrupt_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      pulse_start(md, n);
      wait_done(2000, cyc);
      check("rand_wr_cnt", wr_cnt, n);
      check("rand_mismatch", mismatch, (corrupt_idx != 0));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    corrupt_idx = 0;

    pulse_start(2, 40);
    repeat ($urandom_range(3, 12)) @(posedge clk);
    #2; rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_wr_cnt", wr_cnt, 0);
    check("mid_rst_rd_cnt", rd_cnt, 0);
    check("mid_rst_write_en", fif.write_en, 1'b0);
    check("mid_rst_read_en", fif.read_en, 1'b0);
    check("mid_rst_write_data", fif.write_data, 0);
    rst = 1'b0;
    pulse_start(1, 3);
    wait_done(200, cyc);
    check("post_rst_wdata0", wlog[0], 0);
    check("post_rst_wr_cnt", wr_cnt, 3);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
